// File: rtl/mc8051_intc.sv
// mc8051_intc: 8051-style interrupt controller.
// Five request sources (INT0, T0, INT1, T1, serial) with per-source enables,
// global EA, edge/level trigger on INT0/INT1, fixed index arbitration and a
// req/ack handshake with the CPU.
// Optional macro INTC_NEST_EN: two priority levels with nesting. When it is
// undefined every source is low priority and any in-service level blocks
// further requests.
module mc8051_intc (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] i_irq,
    input  logic [7:0] i_ie,
    input  logic [4:0] i_ip,
    input  logic [1:0] i_it,
    output logic       int_req_n,
    output logic [7:0] int_so_num,
    input  logic       int_ack_n,
    input  logic       int_reti,
    output logic [4:0] o_pending,
    output logic [1:0] o_isr_lvl
);

    typedef enum logic [1:0] {IDLE, REQ, ACKW} state_t;

    state_t     state;
    logic [1:0] irq_hist;    // previous i_irq for INT0 / INT1
    logic [1:0] edge_flag;   // latched edge pending for INT0 / INT1
    logic [1:0] isr;         // in-service: [1] high, [0] low
    logic       win_hi_q;    // priority of the request currently presented

    logic [1:0] rise;
    logic [1:0] edge_clr;
    logic [4:0] pend;
    logic [4:0] prio;
    logic [4:0] en;
    logic [4:0] cand_hi;
    logic [4:0] cand_lo;
    logic       allow_hi;
    logic       allow_lo;
    logic [2:0] win_idx;
    logic       win_hi;
    logic       found;
    logic       eligible;
    logic       ack_fire;
    logic [1:0] isr_nxt;
    logic       unused_bits;

`ifdef INTC_NEST_EN
    assign prio        = i_ip;
    assign allow_hi    = ~isr[1];
    assign allow_lo    = ~isr[1] & ~isr[0];
    assign o_isr_lvl   = isr;
    assign unused_bits = ^i_ie[6:5];
`else
    assign prio        = '0;
    assign allow_hi    = ~(|isr);
    assign allow_lo    = ~(|isr);
    assign o_isr_lvl   = {1'b0, isr[0]};
    assign unused_bits = ^{i_ie[6:5], i_ip};
`endif

    assign rise = {i_irq[2], i_irq[0]} & ~irq_hist;

    assign pend = {i_irq[4],
                   i_irq[3],
                   i_it[1] ? edge_flag[1] : i_irq[2],
                   i_irq[1],
                   i_it[0] ? edge_flag[0] : i_irq[0]};

    assign o_pending = pend;

    assign en      = pend & i_ie[4:0] & {5{i_ie[7]}};
    assign cand_hi = allow_hi ? (en & prio)  : '0;
    assign cand_lo = allow_lo ? (en & ~prio) : '0;

    assign eligible = (|cand_hi) | (|cand_lo);
    assign ack_fire = (state == REQ) && !int_ack_n;

    // Edge flags of the acknowledged winner are consumed on the ack cycle
    assign edge_clr[0] = ack_fire && (int_so_num[2:0] == 3'd0) && i_it[0];
    assign edge_clr[1] = ack_fire && (int_so_num[2:0] == 3'd2) && i_it[1];

    // Winner: any high candidate first, then lowest index within the level
    always_comb begin
        win_idx = '0;
        win_hi  = 1'b0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (cand_hi[i] && !found) begin
                win_idx = 3'(i);
                win_hi  = 1'b1;
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < 5; i++) begin
            if (cand_lo[i] && !found) begin
                win_idx = 3'(i);
                win_hi  = 1'b0;
                found   = 1'b1;
            end
        end
    end

    // In-service update: reti clears the top level before ack sets the new one
    always_comb begin
        isr_nxt = isr;
        if (int_reti) begin
            if (isr[1]) isr_nxt[1] = 1'b0;
            else        isr_nxt[0] = 1'b0;
        end
        if (ack_fire) begin
            if (win_hi_q) isr_nxt[1] = 1'b1;
            else          isr_nxt[0] = 1'b1;
        end
    end

    // Edge detection; a new edge on the ack cycle wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_hist  <= '0;
            edge_flag <= '0;
        end else begin
            irq_hist     <= {i_irq[2], i_irq[0]};
            edge_flag[0] <= i_it[0] ? ((edge_flag[0] & ~edge_clr[0]) | rise[0]) : 1'b0;
            edge_flag[1] <= i_it[1] ? ((edge_flag[1] & ~edge_clr[1]) | rise[1]) : 1'b0;
        end
    end

    // In-service level register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) isr <= '0;
        else          isr <= isr_nxt;
    end

    // Request/acknowledge handshake with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            int_req_n  <= 1'b1;
            int_so_num <= '0;
            win_hi_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state      <= REQ;
                        int_req_n  <= 1'b0;
                        int_so_num <= {5'd0, win_idx};
                        win_hi_q   <= win_hi;
                    end
                end
                REQ: begin
                    if (!int_ack_n) begin
                        state     <= ACKW;
                        int_req_n <= 1'b1;
                    end
                end
                ACKW: begin
                    if (int_ack_n) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    int_req_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc8051_intc.sv
// Directed testbench for mc8051_intc; expectations follow the nesting
// configuration selected by INTC_NEST_EN.
module tb_mc8051_intc;

    logic       clk;
    logic       reset_n;
    logic [4:0] i_irq;
    logic [7:0] i_ie;
    logic [4:0] i_ip;
    logic [1:0] i_it;
    logic       int_req_n;
    logic [7:0] int_so_num;
    logic       int_ack_n;
    logic       int_reti;
    logic [4:0] o_pending;
    logic [1:0] o_isr_lvl;

    int checks = 0;
    int errors = 0;

`ifdef INTC_NEST_EN
    localparam logic [7:0] EXP_HI_ISR = 8'h02;
`else
    localparam logic [7:0] EXP_HI_ISR = 8'h01;
`endif

    mc8051_intc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_irq      (i_irq),
        .i_ie       (i_ie),
        .i_ip       (i_ip),
        .i_it       (i_it),
        .int_req_n  (int_req_n),
        .int_so_num (int_so_num),
        .int_ack_n  (int_ack_n),
        .int_reti   (int_reti),
        .o_pending  (o_pending),
        .o_isr_lvl  (o_isr_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reti_pulse;
        int_reti = 1'b1;
        tick();
        int_reti = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        i_irq     = '0;
        i_ie      = '0;
        i_ip      = '0;
        i_it      = '0;
        int_ack_n = 1'b1;
        int_reti  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_n", 8'(int_req_n), 8'h01);
        check("rst_so_num", int_so_num, 8'h00);
        check("rst_pending", 8'(o_pending), 8'h00);
        check("rst_isr", 8'(o_isr_lvl), 8'h00);
        reset_n = 1'b1;
        tick();

        // Edge-triggered INT0
        i_it  = 2'b01;
        i_ie  = 8'h81;
        i_irq = 5'h01;
        tick();
        check("edge_pend_set", 8'(o_pending), 8'h01);
        check("edge_req_not_yet", 8'(int_req_n), 8'h01);
        i_irq = 5'h00;
        tick();
        check("edge_req", 8'(int_req_n), 8'h00);
        check("edge_so_num", int_so_num, 8'h00);
        int_ack_n = 1'b0;
        tick();
        check("edge_ack_req_n", 8'(int_req_n), 8'h01);
        check("edge_ack_pend", 8'(o_pending), 8'h00);
        check("edge_ack_isr", 8'(o_isr_lvl), 8'h01);
        int_ack_n = 1'b1;
        tick();
        reti_pulse();
        check("edge_reti_isr", 8'(o_isr_lvl), 8'h00);
        reti_pulse();
        check("idle_reti_ignored", 8'(o_isr_lvl), 8'h00);

        // Same-level arbitration on level sources 1,3,4
        i_it  = 2'b00;
        i_ie  = 8'h9F;
        i_ip  = 5'h00;
        i_irq = 5'h1A;
        tick();
        check("arb_req", 8'(int_req_n), 8'h00);
        check("arb_so_num", int_so_num, 8'h01);
        check("arb_pend", 8'(o_pending), 8'h1A);
        i_ie = 8'h1F;
        tick();
        check("frozen_req", 8'(int_req_n), 8'h00);
        check("frozen_so_num", int_so_num, 8'h01);
        i_ie = 8'h9F;
        int_ack_n = 1'b0;
        tick();
        check("arb_ack_req_n", 8'(int_req_n), 8'h01);
        check("arb_ack_isr", 8'(o_isr_lvl), 8'h01);
        check("level_pend_kept", 8'(o_pending), 8'h1A);
        tick();
        check("ackw_no_req", 8'(int_req_n), 8'h01);
        int_ack_n = 1'b1;
        i_irq = 5'h18;
        tick();
        tick();
        check("same_lvl_blocked", 8'(int_req_n), 8'h01);
        reti_pulse();
        check("arb_reti_isr", 8'(o_isr_lvl), 8'h00);
        tick();
        check("arb2_req", 8'(int_req_n), 8'h00);
        check("arb2_so_num", int_so_num, 8'h03);
        int_ack_n = 1'b0;
        tick();
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("arb2_reti_isr", 8'(o_isr_lvl), 8'h00);

        // Nesting: T0 low in service, serial high arrives
        i_ip  = 5'h10;
        i_irq = 5'h02;
        tick();
        check("nest_t0_so_num", int_so_num, 8'h01);
        int_ack_n = 1'b0;
        tick();
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h12;
        tick();
`ifdef INTC_NEST_EN
        check("nest_req", 8'(int_req_n), 8'h00);
        check("nest_so_num", int_so_num, 8'h04);
        int_ack_n = 1'b0;
        tick();
        check("nest_isr_11", 8'(o_isr_lvl), 8'h03);
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("nest_reti1", 8'(o_isr_lvl), 8'h01);
        reti_pulse();
        check("nest_reti2", 8'(o_isr_lvl), 8'h00);
`else
        check("flat_blocked", 8'(int_req_n), 8'h01);
        reti_pulse();
        check("flat_reti_isr", 8'(o_isr_lvl), 8'h00);
        tick();
        check("flat_req", 8'(int_req_n), 8'h00);
        check("flat_so_num", int_so_num, 8'h01);
        int_ack_n = 1'b0;
        tick();
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("flat_reti2", 8'(o_isr_lvl), 8'h00);
`endif

        // Blocking: serial (high when nested) in service, T1 raised
        i_ip  = 5'h18;
        i_irq = 5'h10;
        tick();
        check("blk_so_num", int_so_num, 8'h04);
        int_ack_n = 1'b0;
        tick();
        check("blk_isr", 8'(o_isr_lvl), EXP_HI_ISR);
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h18;
        tick();
        tick();
        check("blk_no_req", 8'(int_req_n), 8'h01);
        reti_pulse();
        check("blk_reti_isr", 8'(o_isr_lvl), 8'h00);
        tick();
        check("blk_req", 8'(int_req_n), 8'h00);
        check("blk_so_num2", int_so_num, 8'h03);
        int_ack_n = 1'b0;
        tick();
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("blk_clean_isr", 8'(o_isr_lvl), 8'h00);

        // reti and ack in the same cycle
`ifdef INTC_NEST_EN
        i_ip  = 5'h10;
        i_irq = 5'h02;
        tick();
        int_ack_n = 1'b0;
        tick();
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h12;
        tick();
        check("ra_so_num", int_so_num, 8'h04);
        int_ack_n = 1'b0;
        int_reti  = 1'b1;
        tick();
        int_reti = 1'b0;
        check("ra_isr_10", 8'(o_isr_lvl), 8'h02);
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("ra_clean_isr", 8'(o_isr_lvl), 8'h00);
`else
        i_ip  = 5'h00;
        i_irq = 5'h02;
        tick();
        check("ra_so_num", int_so_num, 8'h01);
        int_ack_n = 1'b0;
        int_reti  = 1'b1;
        tick();
        int_reti = 1'b0;
        check("ra_isr_01", 8'(o_isr_lvl), 8'h01);
        int_ack_n = 1'b1;
        tick();
        i_irq = 5'h00;
        reti_pulse();
        check("ra_clean_isr", 8'(o_isr_lvl), 8'h00);
`endif

        // Edge re-arriving on the acknowledge cycle
        i_it  = 2'b01;
        i_ie  = 8'h81;
        i_ip  = 5'h00;
        i_irq = 5'h01;
        tick();
        i_irq = 5'h00;
        tick();
        check("rearm_req", 8'(int_req_n), 8'h00);
        int_ack_n = 1'b0;
        i_irq = 5'h01;
        tick();
        check("rearm_pend_kept", 8'(o_pending), 8'h01);
        check("rearm_isr", 8'(o_isr_lvl), 8'h01);
        int_ack_n = 1'b1;
        i_irq = 5'h00;
        tick();
        reti_pulse();
        tick();
        check("rearm_req2", 8'(int_req_n), 8'h00);
        check("rearm_so_num2", int_so_num, 8'h00);
        int_ack_n = 1'b0;
        tick();
        check("rearm_pend_clr", 8'(o_pending), 8'h00);
        int_ack_n = 1'b1;
        tick();
        reti_pulse();

        // EA gating, then reset in the middle of a request
        i_it  = 2'b00;
        i_ie  = 8'h02;
        i_irq = 5'h02;
        tick();
        tick();
        check("ea_off_no_req", 8'(int_req_n), 8'h01);
        i_ie = 8'h82;
        tick();
        check("mid_req", 8'(int_req_n), 8'h00);
        check("mid_so_num", int_so_num, 8'h01);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req_n", 8'(int_req_n), 8'h01);
        check("mid_rst_so_num", int_so_num, 8'h00);
        int_ack_n = 1'b0;
        i_irq = 5'h00;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_req_n", 8'(int_req_n), 8'h01);
        check("post_rst_isr", 8'(o_isr_lvl), 8'h00);
        int_ack_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
